mm_result_engine: RTL and testbench
===================================

Name: mm_result_engine

Overview:
- Datapath responder to the matrix-multiply sequencer (outputs `count`, `load_matrix`, `entry`, `done`). Computes C = A x B for 2x2 unsigned matrices.
- While `load_matrix` is high, it captures operands streamed on `data_in`, indexed by `count`.
- It computes one result element per `entry` step through a 2-stage pipeline and buffers the four results.
- On the rising edge of `done`, it drains the four results over a valid/ready stream toward the store/output side.

Parameters:
- DATA_W, 8, operand width in bits (unsigned).
- RES_W, 2*DATA_W+1, result width; fixed by formula, not to be overridden independently.

Ports:
- clock  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- load_matrix  input  1  operand capture enable from the sequencer.
- count  input  4  operand slot index from the sequencer.
- entry  input  3  result step index from the sequencer.
- done  input  1  sequencer Store indication; level held high by the sequencer.
- data_in  input  DATA_W  operand data, sampled when `load_matrix` is 1.
- res_valid  output  1  result element available.
- res_ready  input  1  downstream accepts the element.
- res_data  output  RES_W  result element value.
- res_index  output  2  element index: 0 = C00, 1 = C01, 2 = C10, 3 = C11.
- unload_done  output  1  one-cycle pulse after C11 is accepted.
- overrun  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (reset == 0, asynchronous):
  - Clears the operand file, result buffer, pipeline valids, `entry_q` and `done_q`.
  - Forces state IDLE.
  - Outputs: res_valid = 0, res_data = 0, res_index = 0, unload_done = 0, overrun = 0.
- Operand capture:
  - Write condition: `load_matrix` == 1 and `count` < 8.
  - Action: `data_in` is written to slot `count[2:0]` on the clock edge.
  - Slot map: 0..3 = A00, A01, A10, A11; 4..7 = B00, B01, B10, B11.
  - `count` >= 8 with `load_matrix` == 1: no write.
  - Operands persist until overwritten or reset.
- Compute issue:
  - `entry_q` is `entry` registered each cycle.
  - Issue condition: `entry` in 1..4 and `entry` != `entry_q`.
  - Action: issue index k = `entry` - 1. Index k targets row i = k[1] and column j = k[0].
  - Stage 1 (issue cycle + 1): register p0 = A[i][0]*B[0][j] and p1 = A[i][1]*B[1][j], each 2*DATA_W bits.
  - Stage 2 (issue cycle + 2): C[k] = p0 + p1, zero-extended to RES_W. This width makes overflow impossible.
  - `entry` = 0 or 5..7: no issue.
  - Back-to-back issues every cycle are supported; the pipeline is fully pipelined.
- State machine:
  - Rising-edge detect on `done`: `done_rise` = `done` & ~`done_q`.
  - IDLE -> WAIT on `done_rise`.
  - WAIT -> UNLOAD when both pipeline stages are empty. WAIT lasts 0 cycles if the pipeline is already empty.
  - UNLOAD:
    - Present res_valid = 1, res_index = idx, res_data = C[idx], starting from idx = 0.
    - Hold res_data and res_index stable while res_valid & ~res_ready.
    - On res_valid & res_ready: if idx < 3, increment idx; if idx = 3, pulse unload_done for 1 cycle, set res_valid = 0 and go to IDLE.
  - `done` held high after the unload completes: no second unload; a fresh rising edge is required.
- Conflicts:
  - `load_matrix` == 1 while in WAIT or UNLOAD:
    - Sets overrun = 1.
    - Drops res_valid the next cycle.
    - Forces IDLE with idx reset to 0.
    - The operand write still occurs.
  - Compute issue while in UNLOAD: the buffer is still written and overrun is set, but the unload continues. Already-presented data may change, which is flagged by overrun.
  - `done_rise` while in WAIT or UNLOAD is ignored.
- Latency:
  - Result k is readable 2 cycles after its issue.
  - First res_valid appears 1 cycle after `done_rise` if the pipeline is empty.

Test Plan:
- Basic product:
  - Stimulus: load A = [1,2;3,4] and B = [5,6;7,8] via count 0..7; step entry 0->1->2->3->4; raise done; hold res_ready = 1.
  - Required: res_data 19, 22, 43, 50 on consecutive cycles with res_index 0..3, then a single unload_done pulse.
- Max values:
  - Stimulus: all operands 255.
  - Required: every result = 130050 (0x1FC02), all 17 bits correct.
- Backpressure:
  - Stimulus: basic product run with res_ready low for 3 cycles on index 1.
  - Required: res_valid stays 1, and res_data = 22 / res_index = 1 hold stable until acceptance.
  - Also required: `done` held high for 20 cycles after completion produces no second unload.
- Boundary indices:
  - Stimulus 1: count = 8..15 with load_matrix = 1 and data 0xAA. Required: operand file unchanged, results unchanged.
  - Stimulus 2: entry 4->5->6. Required: no extra issues.
  - Stimulus 3: done rising 1 cycle after the entry = 4 issue. Required: WAIT holds until C11 is written, and the first res_valid shows 19.
- Overrun:
  - Stimulus: load_matrix = 1 mid-unload at index 2.
  - Required: overrun = 1 (sticky), res_valid = 0 the next cycle, state IDLE; a later done rise unloads starting from index 0.
- Reset:
  - Stimulus: assert reset = 0 asynchronously during UNLOAD.
  - Required: res_valid, unload_done and overrun go to 0 immediately, without waiting for a clock edge.
  - Required after reset release: a done rise with no new loads unloads 0, 0, 0, 0.

Source files
------------

// File: rtl/mm_result_engine.sv
// Result engine for the 2x2 matrix-multiply sequencer: captures operands, computes
// C = A x B through a two-stage pipeline and drains the results over valid/ready.
module mm_result_engine #(
    parameter int DATA_W = 8,
    localparam int RES_W = 2*DATA_W+1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_matrix,
    input  logic [3:0]        count,
    input  logic [2:0]        entry,
    input  logic              done,
    input  logic [DATA_W-1:0] data_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [1:0]        res_index,
    output logic              unload_done,
    output logic              overrun
);
    localparam int PROD_W = 2*DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UNLOAD} state_t;

    logic [DATA_W-1:0] opnd_q [8];
    logic [DATA_W-1:0] opnd_d [8];
    logic [RES_W-1:0]  c_q [4];
    logic [RES_W-1:0]  c_d [4];
    logic [2:0]        entry_q;
    logic              done_q;
    logic              s1_valid_q, s1_valid_d;
    logic [1:0]        s1_k_q, s1_k_d;
    logic [PROD_W-1:0] p0_q, p0_d, p1_q, p1_d;

    state_t            state_q;
    logic              res_valid_q;
    logic [1:0]        idx_q;
    logic              unload_done_q;
    logic              overrun_q;

    logic              write_en;
    logic              issue;
    logic [1:0]        issue_k;
    logic              done_rise;
    logic              pipe_empty;

    assign write_en   = load_matrix && (count < 4'd8);
    assign issue      = (entry >= 3'd1) && (entry <= 3'd4) && (entry != entry_q);
    assign issue_k    = 2'(entry - 3'd1);
    assign done_rise  = done && !done_q;
    assign pipe_empty = !s1_valid_q;

    // Slot map: A row i lives at slots 2i/2i+1, B row r column j at slot 4+2r+j.
    always_comb begin
        opnd_d = opnd_q;
        if (write_en) begin
            opnd_d[count[2:0]] = data_in;
        end

        s1_valid_d = issue;
        s1_k_d     = issue_k;
        p0_d       = PROD_W'(opnd_q[{1'b0, issue_k[1], 1'b0}]) * PROD_W'(opnd_q[{2'b10, issue_k[0]}]);
        p1_d       = PROD_W'(opnd_q[{1'b0, issue_k[1], 1'b1}]) * PROD_W'(opnd_q[{2'b11, issue_k[0]}]);

        c_d = c_q;
        if (s1_valid_q) begin
            c_d[s1_k_q] = RES_W'(p0_q) + RES_W'(p1_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                opnd_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                c_q[i] <= '0;
            end
            entry_q    <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_k_q     <= '0;
            p0_q       <= '0;
            p1_q       <= '0;
        end else begin
            opnd_q     <= opnd_d;
            c_q        <= c_d;
            entry_q    <= entry;
            done_q     <= done;
            s1_valid_q <= s1_valid_d;
            s1_k_q     <= s1_k_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
        end
    end

    // A load during WAIT/UNLOAD aborts the unload; the next done edge restarts from C00.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            res_valid_q   <= 1'b0;
            idx_q         <= '0;
            unload_done_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            unload_done_q <= 1'b0;
            if (issue && state_q == S_UNLOAD) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (done_rise) begin
                        idx_q <= '0;
                        if (pipe_empty) begin
                            state_q     <= S_UNLOAD;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (load_matrix) begin
                        overrun_q   <= 1'b1;
                        res_valid_q <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= S_IDLE;
                    end else if (pipe_empty) begin
                        state_q     <= S_UNLOAD;
                        res_valid_q <= 1'b1;
                        idx_q       <= '0;
                    end
                end
                S_UNLOAD: begin
                    if (load_matrix) begin
                        overrun_q   <= 1'b1;
                        res_valid_q <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= S_IDLE;
                    end else if (res_valid_q && res_ready) begin
                        if (idx_q == 2'd3) begin
                            unload_done_q <= 1'b1;
                            res_valid_q   <= 1'b0;
                            idx_q         <= '0;
                            state_q       <= S_IDLE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    res_valid_q <= 1'b0;
                    idx_q       <= '0;
                end
            endcase
        end
    end

    assign res_valid   = res_valid_q;
    assign res_index   = idx_q;
    assign res_data    = res_valid_q ? c_q[idx_q] : '0;
    assign unload_done = unload_done_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_mm_result_engine.sv
// Directed bench for mm_result_engine: operand capture, products, unload handshake,
// boundary indices, overrun handling and asynchronous reset.
module tb_mm_result_engine;
    logic        clock;
    logic        reset;
    logic        load_matrix;
    logic [3:0]  count;
    logic [2:0]  entry;
    logic        done;
    logic [7:0]  data_in;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_data;
    logic [1:0]  res_index;
    logic        unload_done;
    logic        overrun;

    int          total_checks;
    int          bad_checks;
    logic [2:0]  cur_entry;

    localparam logic [63:0] OPS_BASIC = 64'h0807_0605_0403_0201;
    localparam logic [63:0] OPS_MAX   = 64'hFFFF_FFFF_FFFF_FFFF;

    mm_result_engine #(.DATA_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_matrix (load_matrix),
        .count       (count),
        .entry       (entry),
        .done        (done),
        .data_in     (data_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_index   (res_index),
        .unload_done (unload_done),
        .overrun     (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then land just after the edge that sampled them.
    task automatic applyStimulus(input logic ld, input logic [3:0] cnt, input logic [2:0] ent,
                                 input logic dn, input logic [7:0] dat, input logic rdy);
        load_matrix = ld;
        count       = cnt;
        entry       = ent;
        done        = dn;
        data_in     = dat;
        res_ready   = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic loadOperands(input logic [63:0] ops);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'(i), cur_entry, 1'b0, ops[8*i +: 8], 1'b1);
        end
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic computeAll(input int trailing);
        for (int e = 0; e <= 4; e++) begin
            cur_entry = 3'(e);
            applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
        end
        for (int t = 0; t < trailing; t++) begin
            applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
        end
    endtask

    // Raise done and drain four results; leaves done high on return.
    task automatic unloadAndCheck(input string tag, input logic [16:0] e0, input logic [16:0] e1,
                                  input logic [16:0] e2, input logic [16:0] e3,
                                  input int stall_idx, input int exp_wait);
        logic [16:0] exp_v [4];
        int          idx;
        int          stall;
        int          guard;
        int          wait_cnt;
        logic        seen;
        logic        rdy;
        exp_v[0] = e0;
        exp_v[1] = e1;
        exp_v[2] = e2;
        exp_v[3] = e3;
        idx      = 0;
        stall    = 0;
        guard    = 0;
        wait_cnt = 0;
        seen     = 1'b0;
        rdy      = 1'b1;
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, 1'b1);
        while (idx < 4 && guard < 40) begin
            guard++;
            if (!seen && !res_valid) begin
                wait_cnt++;
                rdy = 1'b1;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    checkOutput({tag, " wait cycles"}, wait_cnt, exp_wait);
                end
                checkOutput({tag, " valid"}, 32'(res_valid), 32'd1);
                checkOutput({tag, " index"}, 32'(res_index), idx);
                checkOutput({tag, " data"}, 32'(res_data), 32'(exp_v[idx]));
                if (idx == stall_idx && stall < 3) begin
                    stall++;
                    rdy = 1'b0;
                end else begin
                    rdy = 1'b1;
                    idx++;
                end
            end
            applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, rdy);
        end
        checkOutput({tag, " all accepted"}, idx, 4);
        checkOutput({tag, " unload_done pulse"}, 32'(unload_done), 32'd1);
        checkOutput({tag, " valid drop"}, 32'(res_valid), 32'd0);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, 1'b1);
        checkOutput({tag, " pulse width"}, 32'(unload_done), 32'd0);
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        cur_entry    = 3'd0;
        reset        = 1'b0;
        load_matrix  = 1'b0;
        count        = 4'd0;
        entry        = 3'd0;
        done         = 1'b0;
        data_in      = 8'd0;
        res_ready    = 1'b1;

        #3;
        checkOutput("reset res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset res_data", 32'(res_data), 32'd0);
        checkOutput("reset res_index", 32'(res_index), 32'd0);
        checkOutput("reset unload_done", 32'(unload_done), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;

        $display("[TB] basic product");
        loadOperands(OPS_BASIC);
        computeAll(2);
        unloadAndCheck("basic", 17'd19, 17'd22, 17'd43, 17'd50, -1, 0);
        checkOutput("basic overrun", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);

        $display("[TB] backpressure");
        unloadAndCheck("stall", 17'd19, 17'd22, 17'd43, 17'd50, 1, 0);
        for (int t = 0; t < 20; t++) begin
            applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, 1'b1);
            checkOutput("done held no reunload", 32'(res_valid), 32'd0);
        end
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);

        $display("[TB] count out of range");
        for (int c = 8; c < 16; c++) begin
            applyStimulus(1'b1, 4'(c), cur_entry, 1'b0, 8'hAA, 1'b1);
        end
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
        computeAll(2);
        unloadAndCheck("count8to15", 17'd19, 17'd22, 17'd43, 17'd50, -1, 0);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);

        $display("[TB] entry out of range");
        loadOperands(OPS_MAX);
        cur_entry = 3'd5;
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
        cur_entry = 3'd6;
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
        unloadAndCheck("entry5to6", 17'd19, 17'd22, 17'd43, 17'd50, -1, 0);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);

        $display("[TB] max values");
        computeAll(2);
        unloadAndCheck("max", 17'h1FC02, 17'h1FC02, 17'h1FC02, 17'h1FC02, -1, 0);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);

        $display("[TB] done right after last issue");
        loadOperands(OPS_BASIC);
        computeAll(0);
        unloadAndCheck("wait state", 17'd19, 17'd22, 17'd43, 17'd50, -1, 1);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);

        $display("[TB] overrun");
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, 1'b1);
        checkOutput("ovr first valid", 32'(res_valid), 32'd1);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, 1'b1);
        checkOutput("ovr at index 2", 32'(res_index), 32'd2);
        checkOutput("ovr data at 2", 32'(res_data), 32'd43);
        applyStimulus(1'b1, 4'd0, cur_entry, 1'b1, 8'd1, 1'b0);
        checkOutput("ovr flag", 32'(overrun), 32'd1);
        checkOutput("ovr valid drop", 32'(res_valid), 32'd0);
        checkOutput("ovr index reset", 32'(res_index), 32'd0);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, 1'b1);
        checkOutput("ovr sticky", 32'(overrun), 32'd1);
        checkOutput("ovr idle", 32'(res_valid), 32'd0);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);
        unloadAndCheck("ovr reunload", 17'd19, 17'd22, 17'd43, 17'd50, -1, 0);
        checkOutput("ovr still sticky", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);

        $display("[TB] async reset during unload");
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b1, 8'd0, 1'b0);
        checkOutput("rst pre valid", 32'(res_valid), 32'd1);
        #2;
        reset     = 1'b0;
        done      = 1'b0;
        cur_entry = 3'd0;
        entry     = 3'd0;
        #1;
        checkOutput("rst async valid", 32'(res_valid), 32'd0);
        checkOutput("rst async unload_done", 32'(unload_done), 32'd0);
        checkOutput("rst async overrun", 32'(overrun), 32'd0);
        checkOutput("rst async data", 32'(res_data), 32'd0);
        #3 reset = 1'b1;
        unloadAndCheck("post reset", 17'd0, 17'd0, 17'd0, 17'd0, -1, 0);
        checkOutput("post reset overrun", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 4'd0, cur_entry, 1'b0, 8'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
